imager_ctrl: RTL
================

# imager_ctrl

Run-control and configuration sequencer for the test-pattern imager. A host register port loads pending imager settings and commands capture runs. The block applies settings only at frame boundaries, gates the imager enable so that frames are never truncated, counts completed frames, and flags a stalled imager with a watchdog.

## Interface
- NUM_ROWS_WIDTH, 12, row-count width; matches the imager.
- NUM_COLS_WIDTH, 12, column-count width; matches the imager.
- TIMEOUT_W, 24, watchdog width; timeout occurs after 2^TIMEOUT_W cycles with no img_start.

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  register write strobe.
- cfg_re  in  1  register read strobe.
- cfg_addr  in  4  register address.
- cfg_wdata  in  16  write data.
- cfg_rdata  out  16  read data, valid 1 cycle after cfg_re.
- img_start  in  1  imager pulse at pixel (0,0).
- img_enable  out  1  imager run enable.
- img_mode  out  4  active mode.
- img_active_rows, img_virtual_rows  out  NUM_ROWS_WIDTH  active row settings.
- img_active_cols, img_virtual_cols  out  NUM_COLS_WIDTH  active column settings.
- img_sync_row_start  out  NUM_ROWS_WIDTH+1  active sync start row.
- img_sync_rows  out  NUM_ROWS_WIDTH  active sync length.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when a run ends normally.
- timeout_err  out  1  sticky; cleared by the next start.

## Operation
- Pending registers, write-only via cfg_we, zero-extended or truncated to field width:
  - 0: mode
  - 1: active rows
  - 2: virtual rows
  - 3: active cols
  - 4: virtual cols
  - 5: sync_row_start
  - 6: sync_rows
  - 7: num_frames (0 means continuous)
- Addr 8 is the control register, write-only, one-shot bits:
  - bit0 start; ignored unless IDLE.
  - bit1 stop; ignored in IDLE.
  - bit2 commit; sets commit_pending.
- Reads:
  - Addr 9 status: {13'b0, timeout_err, commit_pending, busy}.
  - Addr 10: frames_done, 16 bits, saturating.
  - Addr 0-7 read back the pending values.
  - Other addresses read 0.
- Commit rules:
  - In IDLE, pending copies into active outputs on the cycle after the commit write; commit_pending clears.
  - In RUN or DRAIN, the copy happens on the cycle after img_start is sampled high.
  - A write that coincides with the copy lands in pending only. The committed value is the pre-write value.
- State machine IDLE / RUN / DRAIN:
  - IDLE: img_enable=0. On start: frames_done←0, num_frames latched, timeout_err←0, go to RUN.
  - RUN: img_enable=1.
    - The first img_start after entry marks the frame start. Each subsequent img_start increments frames_done.
    - When frames_done reaches a non-zero num_frames on that increment, go to IDLE: img_enable←0, done pulse.
    - stop moves to DRAIN.
  - DRAIN: img_enable=1. On the next img_start: increment frames_done if a frame was already started, img_enable←0, done pulse, go to IDLE.
    - Stop before the first img_start: DRAIN still waits for that first img_start, then ends without incrementing.
- Watchdog:
  - Counter runs in RUN/DRAIN and clears on img_start.
  - At terminal count: timeout_err←1, img_enable←0, go to IDLE. No done pulse.
- Simultaneous events:
  - start and stop in the same write: start wins, stop is ignored.
  - A completing img_start together with a stop write: completion wins, go to IDLE.
  - commit together with start: the commit is applied in IDLE first, so the run begins with the new settings.

## Timing
- Reset values:
  - img_enable=0, busy=0, done=0, timeout_err=0, cfg_rdata=0.
  - All active and pending settings 0, frames_done=0, commit_pending=0, state IDLE.
- Control write at edge N: img_enable=1 and busy=1 visible after edge N+1.
- Terminal img_start sampled at edge M: img_enable=0 and the done pulse appear after edge M+1. busy=0 is visible in the same cycle.
- Commit in a run takes effect one cycle after pixel (0,0). The host must program num_virtual_rows ≥ 2 so that this falls in blanking.
- reset_n asserted mid-run: all outputs return to reset values immediately, asynchronously.

## Test plan
- Reset: assert reset_n low mid-RUN -> img_enable=0 and busy=0 without a clock edge; status reads 0.
- Finite run: num_frames=3, start; drive img_start every 100 cycles -> img_enable falls 1 cycle after the 4th img_start; done pulses once; frames_done=3.
- Stop: continuous run, stop after the 2nd img_start -> enable stays high until the 3rd img_start; frames_done=2; done pulses.
- Commit in run: mode 1→3 commit mid-frame -> img_mode still 1 until 1 cycle after the next img_start, then 3; commit_pending reads 1, then 0.
- Watchdog with TIMEOUT_W=6: start, no img_start -> after 64 cycles timeout_err=1, img_enable=0, no done; next start clears timeout_err.
- Collisions: start+stop in one write -> RUN; stop coincident with the terminal img_start -> single done, IDLE.

Source files
------------

// File: rtl/imager_ctrl.sv
// Run-control and configuration sequencer for the test-pattern imager.
// Settings reach the imager only at frame boundaries. Runs are gated so frames are never cut short.
module imager_ctrl #(
   parameter int NUM_ROWS_WIDTH = 12,
   parameter int NUM_COLS_WIDTH = 12,
   parameter int TIMEOUT_W      = 24
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cfg_we,
   input  logic                      cfg_re,
   input  logic [3:0]                cfg_addr,
   input  logic [15:0]               cfg_wdata,
   output logic [15:0]               cfg_rdata,
   input  logic                      img_start,
   output logic                      img_enable,
   output logic [3:0]                img_mode,
   output logic [NUM_ROWS_WIDTH-1:0] img_active_rows,
   output logic [NUM_ROWS_WIDTH-1:0] img_virtual_rows,
   output logic [NUM_COLS_WIDTH-1:0] img_active_cols,
   output logic [NUM_COLS_WIDTH-1:0] img_virtual_cols,
   output logic [NUM_ROWS_WIDTH:0]   img_sync_row_start,
   output logic [NUM_ROWS_WIDTH-1:0] img_sync_rows,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nxt;

   logic [3:0]                pend_mode;
   logic [NUM_ROWS_WIDTH-1:0] pend_arows, pend_vrows, pend_sync_rows;
   logic [NUM_COLS_WIDTH-1:0] pend_acols, pend_vcols;
   logic [NUM_ROWS_WIDTH:0]   pend_sync_start;
   logic [15:0]               pend_num_frames;

   logic [15:0]          num_frames, num_frames_nxt;
   logic [15:0]          frames_done, frames_done_nxt, frames_inc;
   logic                 started, started_nxt;
   logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_nxt;
   logic                 done_nxt, timeout_nxt;
   logic                 start_q, stop_q, img_start_q;
   logic                 commit_pending, commit_fire;
   logic                 ctrl_wr, wd_term, run_start;

   assign ctrl_wr     = cfg_we && (cfg_addr == 4'd8);
   assign frames_inc  = (frames_done == 16'hFFFF) ? frames_done : frames_done + 16'd1;
   assign wd_term     = (wd_cnt == {TIMEOUT_W{1'b1}});
   assign commit_fire = commit_pending && ((state == IDLE) || img_start_q);

   assign img_enable = (state != IDLE);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt       = state;
      done_nxt        = 1'b0;
      timeout_nxt     = timeout_err;
      frames_done_nxt = frames_done;
      num_frames_nxt  = num_frames;
      started_nxt     = started;
      run_start       = 1'b0;
      case (state)
         IDLE: begin
            if (start_q) begin
               run_start       = 1'b1;
               state_nxt       = RUN;
               frames_done_nxt = 16'd0;
               num_frames_nxt  = pend_num_frames;
               timeout_nxt     = 1'b0;
               started_nxt     = 1'b0;
            end
         end
         RUN: begin
            if (img_start_q) begin
               if (!started) begin
                  started_nxt = 1'b1;
               end else begin
                  frames_done_nxt = frames_inc;
                  if ((num_frames != 16'd0) && (frames_inc == num_frames)) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end else if (wd_term) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
            // A completing frame or a timeout takes precedence over stop.
            if (stop_q && (state_nxt == RUN))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (img_start_q) begin
               if (started)
                  frames_done_nxt = frames_inc;
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (wd_term) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      wd_cnt_nxt = wd_cnt;
      if (run_start || img_start_q || (state_nxt == IDLE))
         wd_cnt_nxt = '0;
      else if (state != IDLE)
         wd_cnt_nxt = wd_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         frames_done <= '0;
         num_frames  <= '0;
         started     <= 1'b0;
         wd_cnt      <= '0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         img_start_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         done        <= done_nxt;
         timeout_err <= timeout_nxt;
         frames_done <= frames_done_nxt;
         num_frames  <= num_frames_nxt;
         started     <= started_nxt;
         wd_cnt      <= wd_cnt_nxt;
         start_q     <= ctrl_wr && cfg_wdata[0];
         stop_q      <= ctrl_wr && cfg_wdata[1];
         img_start_q <= img_start;
      end
   end

   // A fresh commit write wins over the clear from a copy on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         commit_pending <= 1'b0;
      else if (ctrl_wr && cfg_wdata[2])
         commit_pending <= 1'b1;
      else if (commit_fire)
         commit_pending <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_mode       <= '0;
         pend_arows      <= '0;
         pend_vrows      <= '0;
         pend_acols      <= '0;
         pend_vcols      <= '0;
         pend_sync_start <= '0;
         pend_sync_rows  <= '0;
         pend_num_frames <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            4'd0: pend_mode       <= cfg_wdata[3:0];
            4'd1: pend_arows      <= NUM_ROWS_WIDTH'(cfg_wdata);
            4'd2: pend_vrows      <= NUM_ROWS_WIDTH'(cfg_wdata);
            4'd3: pend_acols      <= NUM_COLS_WIDTH'(cfg_wdata);
            4'd4: pend_vcols      <= NUM_COLS_WIDTH'(cfg_wdata);
            4'd5: pend_sync_start <= (NUM_ROWS_WIDTH+1)'(cfg_wdata);
            4'd6: pend_sync_rows  <= NUM_ROWS_WIDTH'(cfg_wdata);
            4'd7: pend_num_frames <= cfg_wdata;
            default: ;
         endcase
      end
   end

   // Copy uses the pre-write pending values; a coincident write lands in pending only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         img_mode           <= '0;
         img_active_rows    <= '0;
         img_virtual_rows   <= '0;
         img_active_cols    <= '0;
         img_virtual_cols   <= '0;
         img_sync_row_start <= '0;
         img_sync_rows      <= '0;
      end else if (commit_fire) begin
         img_mode           <= pend_mode;
         img_active_rows    <= pend_arows;
         img_virtual_rows   <= pend_vrows;
         img_active_cols    <= pend_acols;
         img_virtual_cols   <= pend_vcols;
         img_sync_row_start <= pend_sync_start;
         img_sync_rows      <= pend_sync_rows;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_rdata <= '0;
      end else if (cfg_re) begin
         case (cfg_addr)
            4'd0:    cfg_rdata <= 16'(pend_mode);
            4'd1:    cfg_rdata <= 16'(pend_arows);
            4'd2:    cfg_rdata <= 16'(pend_vrows);
            4'd3:    cfg_rdata <= 16'(pend_acols);
            4'd4:    cfg_rdata <= 16'(pend_vcols);
            4'd5:    cfg_rdata <= 16'(pend_sync_start);
            4'd6:    cfg_rdata <= 16'(pend_sync_rows);
            4'd7:    cfg_rdata <= pend_num_frames;
            4'd9:    cfg_rdata <= {13'b0, timeout_err, commit_pending, busy};
            4'd10:   cfg_rdata <= frames_done;
            default: cfg_rdata <= '0;
         endcase
      end
   end

endmodule
